// File: rtl/wb_stage_pkg.sv
// Shared settings for the writeback stage: default widths and the load-wait FSM encoding.
package wb_stage_pkg;

  localparam int DEF_WORD_WIDTH     = 32;
  localparam int DEF_REG_FILE_DEPTH = 4;
  localparam int DEF_LOAD_TIMEOUT   = 16;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register with a hold enable; every field clears on asynchronous reset.
module wb_pipe_reg
  import wb_stage_pkg::*;
#(
  parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
  parameter int REG_FILE_DEPTH = DEF_REG_FILE_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold_i,
  input  logic                      valid_i,
  input  logic                      wb_en_i,
  input  logic                      mem_read_i,
  input  logic [REG_FILE_DEPTH-1:0] dst_i,
  input  logic [WORD_WIDTH-1:0]     alu_result_i,
  output logic                      valid_o,
  output logic                      wb_en_o,
  output logic                      mem_read_o,
  output logic [REG_FILE_DEPTH-1:0] dst_o,
  output logic [WORD_WIDTH-1:0]     alu_result_o
);

  logic                      valid_q;
  logic                      wb_en_q;
  logic                      mem_read_q;
  logic [REG_FILE_DEPTH-1:0] dst_q;
  logic [WORD_WIDTH-1:0]     alu_result_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      wb_en_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      dst_q        <= '0;
      alu_result_q <= '0;
    end else if (!hold_i) begin
      valid_q      <= valid_i;
      wb_en_q      <= wb_en_i;
      mem_read_q   <= mem_read_i;
      dst_q        <= dst_i;
      alu_result_q <= alu_result_i;
    end
  end

  assign valid_o      = valid_q;
  assign wb_en_o      = wb_en_q;
  assign mem_read_o   = mem_read_q;
  assign dst_o        = dst_q;
  assign alu_result_o = alu_result_q;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, ALU/load writeback mux and a wait FSM that stalls
// the pipeline on slow SRAM reads until data arrives or the load times out.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
  parameter int REG_FILE_DEPTH = DEF_REG_FILE_DEPTH,
  parameter int LOAD_TIMEOUT   = DEF_LOAD_TIMEOUT,
  parameter int CNT_WIDTH      = $clog2(LOAD_TIMEOUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_valid,
  input  logic                      mem_WB_en,
  input  logic                      mem_read,
  input  logic [REG_FILE_DEPTH-1:0] mem_dst,
  input  logic [WORD_WIDTH-1:0]     mem_alu_result,
  input  logic [WORD_WIDTH-1:0]     sram_rdata,
  input  logic                      sram_rdata_valid,
  output logic [REG_FILE_DEPTH-1:0] reg_file_wb_address,
  output logic [WORD_WIDTH-1:0]     reg_file_wb_data,
  output logic                      reg_file_enable,
  output logic                      stall,
  output logic                      load_timeout_err
);

  logic                      r_valid_q;
  logic                      r_wb_en_q;
  logic                      r_mem_read_q;
  logic [REG_FILE_DEPTH-1:0] r_dst_q;
  logic [WORD_WIDTH-1:0]     r_alu_q;

  wb_state_e                 state_q;
  logic [CNT_WIDTH-1:0]      cnt_q;
  logic                      err_q;

  logic                      load_pending;
  logic                      load_done;
  logic                      alu_write;
  logic                      timeout_hit;

  wb_pipe_reg #(
    .WORD_WIDTH     (WORD_WIDTH),
    .REG_FILE_DEPTH (REG_FILE_DEPTH)
  ) u_pipe_reg (
    .clk          (clk),
    .rst          (rst),
    .hold_i       (stall),
    .valid_i      (mem_valid),
    .wb_en_i      (mem_WB_en),
    .mem_read_i   (mem_read),
    .dst_i        (mem_dst),
    .alu_result_i (mem_alu_result),
    .valid_o      (r_valid_q),
    .wb_en_o      (r_wb_en_q),
    .mem_read_o   (r_mem_read_q),
    .dst_o        (r_dst_q),
    .alu_result_o (r_alu_q)
  );

  // A load always writes back, regardless of its WB_en bit.
  always_comb begin
    load_pending = r_valid_q & r_mem_read_q;
    load_done    = load_pending & sram_rdata_valid;
    alu_write    = r_valid_q & ~r_mem_read_q & r_wb_en_q;
    timeout_hit  = (state_q == WB_WAIT) & ~sram_rdata_valid
                   & (cnt_q == CNT_WIDTH'(LOAD_TIMEOUT));
  end

  always_comb begin
    reg_file_enable     = load_done | alu_write;
    stall               = load_pending & ~sram_rdata_valid & ~timeout_hit;
    reg_file_wb_address = r_valid_q ? r_dst_q : '0;
    reg_file_wb_data    = '0;
    if (load_done) begin
      reg_file_wb_data = sram_rdata;
    end else if (alu_write) begin
      reg_file_wb_data = r_alu_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WB_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        WB_IDLE: begin
          if (load_pending && !sram_rdata_valid) begin
            state_q <= WB_WAIT;
            cnt_q   <= CNT_WIDTH'(1);
          end
        end
        WB_WAIT: begin
          if (sram_rdata_valid) begin
            state_q <= WB_IDLE;
            cnt_q   <= '0;
          end else if (timeout_hit) begin
            // The load retires with no write; the sticky flag records it.
            state_q <= WB_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_q <= WB_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign load_timeout_err = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with LOAD_TIMEOUT=4: ALU writes, loads, timeout, bubbles, reset.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_WB_en;
  logic        mem_read;
  logic [3:0]  mem_dst;
  logic [31:0] mem_alu_result;
  logic [31:0] sram_rdata;
  logic        sram_rdata_valid;
  logic [3:0]  reg_file_wb_address;
  logic [31:0] reg_file_wb_data;
  logic        reg_file_enable;
  logic        stall;
  logic        load_timeout_err;

  int tests;
  int fails;

  // {enable, address, data, stall}
  logic [37:0] obs;
  logic [37:0] exp_v;
  assign obs = {reg_file_enable, reg_file_wb_address, reg_file_wb_data, stall};

  wb_stage #(
    .WORD_WIDTH     (32),
    .REG_FILE_DEPTH (4),
    .LOAD_TIMEOUT   (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .mem_valid           (mem_valid),
    .mem_WB_en           (mem_WB_en),
    .mem_read            (mem_read),
    .mem_dst             (mem_dst),
    .mem_alu_result      (mem_alu_result),
    .sram_rdata          (sram_rdata),
    .sram_rdata_valid    (sram_rdata_valid),
    .reg_file_wb_address (reg_file_wb_address),
    .reg_file_wb_data    (reg_file_wb_data),
    .reg_file_enable     (reg_file_enable),
    .stall               (stall),
    .load_timeout_err    (load_timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic set_mem(input logic v, input logic wb, input logic rd,
                         input logic [3:0] d, input logic [31:0] a);
    mem_valid      = v;
    mem_WB_en      = wb;
    mem_read       = rd;
    mem_dst        = d;
    mem_alu_result = a;
  endtask

  task automatic set_sram(input logic v, input logic [31:0] d);
    sram_rdata_valid = v;
    sram_rdata       = d;
  endtask

  // Inputs are applied at the falling edge; outputs are sampled 1ns later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_mem(0, 0, 0, 4'd0, 32'h0);
    set_sram(0, 32'h0);
    #2;
    exp_v = '0;
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected %h", obs, exp_v);
    end
    tests++;
    if (load_timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_err: got %0b expected 0", load_timeout_err);
    end
    cyc();
    rst = 1'b0;
    $display("[TB] reset released");
  endtask

  task automatic test_alu_op();
    cyc();
    set_mem(1, 1, 0, 4'd3, 32'h0000_0042);
    cyc();
    set_mem(0, 0, 0, 4'd0, 32'h0);
    #1;
    exp_v = {1'b1, 4'd3, 32'h0000_0042, 1'b0};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL alu_write: got %h expected %h", obs, exp_v);
    end
    $display("[TB] alu op r3 <= 0x42");
    cyc();
    #1;
    exp_v = '0;
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL alu_single_write: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_zero_wait_load();
    cyc();
    set_mem(1, 0, 1, 4'd5, 32'h0000_0100);
    cyc();
    set_mem(0, 0, 0, 4'd0, 32'h0);
    set_sram(1, 32'hDEAD_BEEF);
    #1;
    exp_v = {1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL zero_wait_load: got %h expected %h", obs, exp_v);
    end
    $display("[TB] zero-wait load r5 <= 0xdeadbeef");
    cyc();
    set_sram(0, 32'h0);
    #1;
    exp_v = '0;
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL zero_wait_no_repeat: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_three_cycle_load();
    cyc();
    set_mem(1, 1, 1, 4'd7, 32'h0000_0200);
    cyc();
    set_mem(1, 1, 0, 4'd9, 32'h0000_0077);
    #1;
    exp_v = {1'b0, 4'd7, 32'h0, 1'b1};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL load3_stall_idle: got %h expected %h", obs, exp_v);
    end
    for (int i = 1; i <= 2; i++) begin
      cyc();
      #1;
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL load3_stall_wait%0d: got %h expected %h", i, obs, exp_v);
      end
    end
    cyc();
    set_sram(1, 32'h0000_1234);
    #1;
    exp_v = {1'b1, 4'd7, 32'h0000_1234, 1'b0};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL load3_write: got %h expected %h", obs, exp_v);
    end
    $display("[TB] 3-cycle load r7 <= 0x1234");
    cyc();
    set_sram(0, 32'h0);
    set_mem(0, 0, 0, 4'd0, 32'h0);
    #1;
    exp_v = {1'b1, 4'd9, 32'h0000_0077, 1'b0};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL load3_held_alu: got %h expected %h", obs, exp_v);
    end
    $display("[TB] held alu op r9 <= 0x77");
    cyc();
    #1;
    exp_v = '0;
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL load3_after: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_timeout();
    tests++;
    if (load_timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_err_before: got %0b expected 0", load_timeout_err);
    end
    cyc();
    set_mem(1, 1, 1, 4'd2, 32'h0000_0300);
    cyc();
    set_mem(1, 1, 0, 4'd4, 32'h0000_0055);
    exp_v = {1'b0, 4'd2, 32'h0, 1'b1};
    #1;
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL timeout_stall0: got %h expected %h", obs, exp_v);
    end
    for (int i = 1; i <= 3; i++) begin
      cyc();
      #1;
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL timeout_stall%0d: got %h expected %h", i, obs, exp_v);
      end
    end
    cyc();
    #1;
    exp_v = {1'b0, 4'd2, 32'h0, 1'b0};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL timeout_release: got %h expected %h", obs, exp_v);
    end
    $display("[TB] load r2 abandoned after timeout");
    cyc();
    set_mem(0, 0, 0, 4'd0, 32'h0);
    #1;
    exp_v = {1'b1, 4'd4, 32'h0000_0055, 1'b0};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL timeout_next_alu: got %h expected %h", obs, exp_v);
    end
    tests++;
    if (load_timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_err_set: got %0b expected 1", load_timeout_err);
    end
    $display("[TB] alu op r4 <= 0x55 after timeout");
    cyc();
    cyc();
    #1;
    tests++;
    if (load_timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_err_sticky: got %0b expected 1", load_timeout_err);
    end
  endtask

  task automatic test_bubble_spurious();
    cyc();
    set_mem(0, 1, 0, 4'd6, 32'h0000_00AA);
    cyc();
    set_mem(1, 0, 0, 4'd8, 32'h0000_00BB);
    set_sram(1, 32'h0000_CAFE);
    #1;
    exp_v = '0;
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL bubble: got %h expected %h", obs, exp_v);
    end
    $display("[TB] bubble with spurious sram valid");
    cyc();
    set_mem(0, 0, 0, 4'd0, 32'h0);
    #1;
    exp_v = {1'b0, 4'd8, 32'h0, 1'b0};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL non_writing_op: got %h expected %h", obs, exp_v);
    end
    $display("[TB] non-writing op r8 with spurious sram valid");
    cyc();
    set_sram(0, 32'h0);
    #1;
    exp_v = '0;
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL spurious_after: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid_wait();
    cyc();
    set_mem(1, 1, 1, 4'd11, 32'h0000_0400);
    cyc();
    set_mem(0, 0, 0, 4'd0, 32'h0);
    cyc();
    cyc();
    #1;
    exp_v = {1'b0, 4'd11, 32'h0, 1'b1};
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL rst_wait_pre: got %h expected %h", obs, exp_v);
    end
    rst = 1'b1;
    #1;
    exp_v = '0;
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL rst_async_outputs: got %h expected %h", obs, exp_v);
    end
    tests++;
    if (load_timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_async_err: got %0b expected 0", load_timeout_err);
    end
    $display("[TB] reset pulsed in WAIT cycle 2");
    cyc();
    rst = 1'b0;
    set_sram(1, 32'h0000_0999);
    #1;
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL rst_late_valid: got %h expected %h", obs, exp_v);
    end
    cyc();
    #1;
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL rst_late_valid2: got %h expected %h", obs, exp_v);
    end
    set_sram(0, 32'h0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_alu_op();
    test_zero_wait_load();
    test_three_cycle_load();
    test_timeout();
    test_bubble_spurious();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage. Final stage of the five-stage pipeline and the producer of the decode stage's register-file write port (`reg_file_wb_address`, `reg_file_wb_data`, `reg_file_enable`).
- Holds the MEM/WB pipeline register and selects ALU result or load data as the writeback value.
- Absorbs variable-latency SRAM read data through a small wait state machine. Stalls the pipeline until the data arrives or a timeout expires.

Parameters:
- WORD_WIDTH, 32, datapath width.
- REG_FILE_DEPTH, 4, register index width.
- LOAD_TIMEOUT, 16, maximum WAIT cycles before a load is abandoned (≥1).
- CNT_WIDTH, $clog2(LOAD_TIMEOUT+1), wait counter width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_valid  in  1  MEM stage presents a valid instruction.
- mem_WB_en  in  1  instruction writes a register.
- mem_read  in  1  instruction is a load.
- mem_dst  in  REG_FILE_DEPTH  destination register.
- mem_alu_result  in  WORD_WIDTH  ALU result / address.
- sram_rdata  in  WORD_WIDTH  load data.
- sram_rdata_valid  in  1  sram_rdata valid this cycle.
- reg_file_wb_address  out  REG_FILE_DEPTH  write address.
- reg_file_wb_data  out  WORD_WIDTH  write data.
- reg_file_enable  out  1  write strobe, single cycle per instruction.
- stall  out  1  freeze all upstream pipeline registers.
- load_timeout_err  out  1  sticky; set when a load is abandoned.

Behaviour:
- Pipeline register R = {valid, WB_en, mem_read, dst, alu_result}.
  - Reset: all fields 0.
  - Edge with stall=0: R <= MEM inputs (valid=mem_valid).
  - Edge with stall=1: R holds.
- States: IDLE, WAIT. Reset state IDLE; wait counter cnt=0.
- IDLE:
  - R.valid & R.mem_read & sram_rdata_valid: write sram_rdata to R.dst this cycle; stall=0.
  - R.valid & R.mem_read & !sram_rdata_valid: no write; stall=1; next state WAIT; cnt<=1.
  - R.valid & !R.mem_read & R.WB_en: write R.alu_result; stall=0.
  - Otherwise: no write; stall=0.
- WAIT:
  - sram_rdata_valid: write sram_rdata to R.dst this cycle; stall=0; next state IDLE; cnt<=0.
  - !sram_rdata_valid & cnt==LOAD_TIMEOUT: no write; stall=0; load_timeout_err<=1; next state IDLE; cnt<=0.
  - Otherwise: stall=1; cnt<=cnt+1.
- A load writes regardless of R.WB_en; mem_read implies writeback.
- reg_file_enable, reg_file_wb_address and reg_file_wb_data are combinational from R, the state and the sram inputs.
  - address = R.dst whenever R.valid, else 0.
  - data = 0 when enable=0.
- Write latency: non-load, one cycle after MEM capture. Load, one cycle plus SRAM wait cycles.
- sram_rdata_valid outside a pending load is ignored.
- Exactly one write per instruction, never repeated. stall=0 on the write cycle advances R.
- Worst-case stall length is LOAD_TIMEOUT cycles. After timeout the abandoned instruction retires with no write.
- load_timeout_err clears only on rst.
- rst mid-WAIT: immediate return to IDLE; R, cnt and all outputs 0; no write.
- Reset values: reg_file_enable=0, address=0, data=0, stall=0, load_timeout_err=0.

Decomposition:
- Shared settings header: WORD_WIDTH, REG_FILE_DEPTH, WB state encodings (IDLE=1'b0, WAIT=1'b1).
- One natural sub-module: wb_pipe_reg, the MEM/WB register with hold-enable and asynchronous reset.
- Writeback mux and FSM stay inline.

Test Plan:
- ALU op: mem_valid=1, WB_en=1, dst=3, alu_result=0x0000_0042 → next cycle enable=1, addr=3, data=0x42, stall=0.
- Zero-wait load: mem_read=1, dst=5, sram_rdata_valid=1 with rdata=0xDEADBEEF in capture+1 cycle → single write r5=0xDEADBEEF, stall never 1.
- 3-cycle load: valid asserted at WAIT cycle 3, rdata=0x1234 → stall=1 for 3 cycles, then write r-dst=0x1234. Following ALU op held in R until then and written the next cycle.
- Timeout with LOAD_TIMEOUT=4, valid never asserted → stall high 4 cycles, no write, load_timeout_err=1 and stays 1. A subsequent ALU op writes normally.
- Reset mid-WAIT: rst pulsed in WAIT cycle 2 → outputs 0 asynchronously; late sram_rdata_valid after reset causes no write.
- Bubble and non-writing op: mem_valid=0, or WB_en=0 & mem_read=0 → enable=0 and data=0. Spurious sram_rdata_valid=1 is ignored.
